cache_bank: RTL and testbench
=============================

CACHE_BANK -- requirements
Module: cache_bank

Interface
REQ-001 Parameters SHALL be: LINES, 16, number of lines; WORDS, 4, 16-bit words per line; TAG_W, 5, tag width; DATA_W, 16, word width.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 en  input  1  request strobe from the controller; held until ack is seen.
REQ-005 index  input  [0:3]  line select.
REQ-006 word  input  [0:1]  word-in-line select.
REQ-007 comp  input  1  1 = compare (tagged) access; 0 = direct access.
REQ-008 write  input  1  1 = write, 0 = read.
REQ-009 tag_in  input  [0:4]  request tag.
REQ-010 data_in  input  [0:15]  write data.
REQ-011 valid_in  input  1  valid bit stored on direct write.
REQ-012 flush  input  1  sampled with en; 1 = invalidate all lines instead of access.
REQ-013 hit, dirty, valid  output  1 each  registered access results.
REQ-014 tag_out  output  [0:4]  stored tag of the addressed line.
REQ-015 data_out  output  [0:15]  stored word.
REQ-016 ack  output  1  result valid; high only in ACK.
REQ-017 ready  output  1  high only in IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, FLUSH, ACK.
REQ-019 IDLE with en=1 and flush=0: capture all request inputs, go to ACCESS.
REQ-020 IDLE with en=1 and flush=1: clear line counter, go to FLUSH.
REQ-021 ACCESS: perform the operation, register the outputs, go to ACK; ack rises 2 cycles after en is sampled.
REQ-022 Compare read: hit = valid[idx] & (tag[idx]==tag_in); outputs are the stored data, tag, valid and dirty; no array change.
REQ-023 Compare write: when hit, write data_in to the addressed word and set dirty[idx]; on a miss, no array change; outputs are the stored pre-write values.
REQ-024 Direct read: hit=0; outputs are the stored values regardless of tag.
REQ-025 Direct write: write tag_in, data_in at word, valid[idx]=valid_in, dirty[idx]=0; hit=0; outputs are the new values.
REQ-026 FLUSH: clear valid and dirty of line counter, one line per cycle, for 16 cycles (counter 0..15, no wrap); then go to ACK with hit=dirty=valid=0 and tag_out=data_out=0.
REQ-027 ACK: hold outputs stable; go to IDLE on the first cycle en=0 is sampled; stay in ACK while en=1.
REQ-028 en dropping during ACCESS or FLUSH: the operation completes; ack SHALL be high for exactly 1 cycle.
REQ-029 Request inputs changing after capture SHALL have no effect on the operation in flight.
REQ-030 Outputs SHALL change only on the ACCESS->ACK or FLUSH->ACK transition.

Reset
REQ-031 rst_n=0 SHALL force state FLUSH with counter 0, and set hit, dirty, valid, tag_out, data_out and ack to 0.
REQ-032 After release, the FLUSH walk SHALL complete, with ready=0 throughout, and then enter IDLE directly without ack.
REQ-033 rst_n=0 mid-operation SHALL abort it; array writes not yet performed SHALL be lost.

Structure
REQ-034 A shared cache_pkg SHALL hold the widths, the line and word counts, and the FSM state encoding.
REQ-035 Storage SHALL be one sub-module, cache_array: data, tag, valid and dirty, with a single read/write port and a line-clear port.

Verification
REQ-036 Reset, then poll ready -> ready=1 exactly 16 cycles after rst_n release; ack never high.
REQ-037 Direct write idx=3 word=2 tag=5'h0A data=16'hBEEF valid_in=1, then compare read same idx/word/tag -> hit=1 data_out=16'hBEEF valid=1 dirty=0.
REQ-038 Compare write idx=3 word=1 tag=5'h0A data=16'h1234, then compare read word 1 -> hit=1 dirty=1 data_out=16'h1234.
REQ-039 Compare read idx=3 tag=5'h0B -> hit=0 tag_out=5'h0A valid=1.
REQ-040 flush request, then compare read idx=3 tag=5'h0A -> ack 17 cycles after en; then hit=0 valid=0 dirty=0.
REQ-041 en dropped 1 cycle after capture -> 1-cycle ack pulse; back in IDLE next cycle.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared widths, line/word counts, FSM encoding and request record for the cache bank.
package cache_pkg;

  localparam int CACHE_LINES  = 16;
  localparam int CACHE_WORDS  = 4;
  localparam int CACHE_TAG_W  = 5;
  localparam int CACHE_DATA_W = 16;

  localparam int IDX_W = $clog2(CACHE_LINES);
  localparam int WRD_W = $clog2(CACHE_WORDS);

  // state    | meaning
  // ST_IDLE  | waiting for a request, ready high
  // ST_ACCESS| captured request is executed against the array
  // ST_FLUSH | walking the lines, clearing valid/dirty one per cycle
  // ST_ACK   | results held, ack high until en drops
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_ACK    = 2'd3;

  typedef logic [IDX_W-1:0]        idx_t;
  typedef logic [WRD_W-1:0]        wrd_t;
  typedef logic [CACHE_TAG_W-1:0]  tag_t;
  typedef logic [CACHE_DATA_W-1:0] data_t;

  typedef struct packed {
    idx_t  index;
    wrd_t  word;
    logic  comp;
    logic  write;
    tag_t  tag;
    data_t data;
    logic  valid;
  } req_t;

endpackage

// File: rtl/cache_bank_if.sv
// Request/result bus between a controller (master) and the cache bank (slave).
interface cache_bank_if;
  import cache_pkg::*;

  logic  en;
  idx_t  index;
  wrd_t  word;
  logic  comp;
  logic  write;
  tag_t  tag_in;
  data_t data_in;
  logic  valid_in;
  logic  flush;

  logic  hit;
  logic  dirty;
  logic  valid;
  tag_t  tag_out;
  data_t data_out;
  logic  ack;
  logic  ready;

  modport master (
    output en, index, word, comp, write, tag_in, data_in, valid_in, flush,
    input  hit, dirty, valid, tag_out, data_out, ack, ready
  );

  modport slave (
    input  en, index, word, comp, write, tag_in, data_in, valid_in, flush,
    output hit, dirty, valid, tag_out, data_out, ack, ready
  );

endinterface

// File: rtl/cache_array.sv
// Line storage: data words, tag, valid and dirty per line. One combinational
// read / clocked write port addressed by line+word, plus a line-clear port
// that drops valid and dirty of one line.
module cache_array #(
  parameter int LINES  = 16,
  parameter int WORDS  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic [$clog2(LINES)-1:0] line_i,
  input  logic [$clog2(WORDS)-1:0] word_i,
  input  logic                     we_i,
  input  logic [TAG_W-1:0]         wr_tag_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     wr_valid_i,
  input  logic                     wr_dirty_i,
  input  logic                     clr_i,
  input  logic [$clog2(LINES)-1:0] clr_line_i,
  output logic [TAG_W-1:0]         rd_tag_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_valid_o,
  output logic                     rd_dirty_o
);

  logic [DATA_W-1:0] data_q [LINES][WORDS];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;

  // Storage update: line write, then line clear (never both in one cycle).
  always_ff @(posedge clk) begin
    if (we_i) begin
      data_q[line_i][word_i] <= wr_data_i;
      tag_q[line_i]          <= wr_tag_i;
      valid_q[line_i]        <= wr_valid_i;
      dirty_q[line_i]        <= wr_dirty_i;
    end
    if (clr_i) begin
      valid_q[clr_line_i] <= 1'b0;
      dirty_q[clr_line_i] <= 1'b0;
    end
  end

  assign rd_data_o  = data_q[line_i][word_i];
  assign rd_tag_o   = tag_q[line_i];
  assign rd_valid_o = valid_q[line_i];
  assign rd_dirty_o = dirty_q[line_i];

endmodule

// File: rtl/cache_bank.sv
// Cache bank controller: captures a request, runs a compare/direct read/write
// or a full-bank flush, and presents registered results under an ack handshake.
// Reset lands in the flush walk so the bank always starts with no valid lines.
module cache_bank
  import cache_pkg::*;
#(
  parameter int LINES  = CACHE_LINES,
  parameter int WORDS  = CACHE_WORDS,
  parameter int TAG_W  = CACHE_TAG_W,
  parameter int DATA_W = CACHE_DATA_W
) (
  input logic         clk,
  input logic         rst_n,
  cache_bank_if.slave bus
);

  logic [1:0] state_q, state_d;
  idx_t       cnt_q, cnt_d;
  logic       from_rst_q, from_rst_d;
  req_t       req_q, req_d;
  logic       hit_q, hit_d;
  logic       dirty_q, dirty_d;
  logic       valid_q, valid_d;
  tag_t       tag_q, tag_d;
  data_t      data_q, data_d;

  logic  arr_we, arr_clr;
  tag_t  arr_wr_tag, arr_rd_tag;
  data_t arr_wr_data, arr_rd_data;
  logic  arr_wr_valid, arr_wr_dirty;
  logic  arr_rd_valid, arr_rd_dirty;
  logic  we_c, clr_c, hit_c;

  cache_array #(
    .LINES  (LINES),
    .WORDS  (WORDS),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk        (clk),
    .line_i     (req_q.index),
    .word_i     (req_q.word),
    .we_i       (arr_we),
    .wr_tag_i   (arr_wr_tag),
    .wr_data_i  (arr_wr_data),
    .wr_valid_i (arr_wr_valid),
    .wr_dirty_i (arr_wr_dirty),
    .clr_i      (arr_clr),
    .clr_line_i (cnt_q),
    .rd_tag_o   (arr_rd_tag),
    .rd_data_o  (arr_rd_data),
    .rd_valid_o (arr_rd_valid),
    .rd_dirty_o (arr_rd_dirty)
  );

  // A cycle with rst_n low must not commit anything to the array.
  assign arr_we  = we_c & rst_n;
  assign arr_clr = clr_c & rst_n;

  assign hit_c = req_q.comp & arr_rd_valid & (arr_rd_tag == req_q.tag);

  // Next-state, request capture, array control and result computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    from_rst_d   = from_rst_q;
    req_d        = req_q;
    hit_d        = hit_q;
    dirty_d      = dirty_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    we_c         = 1'b0;
    clr_c        = 1'b0;
    arr_wr_tag   = req_q.tag;
    arr_wr_data  = req_q.data;
    arr_wr_valid = req_q.valid;
    arr_wr_dirty = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          if (bus.flush) begin
            cnt_d      = '0;
            from_rst_d = 1'b0;
            state_d    = ST_FLUSH;
          end else begin
            req_d.index = bus.index;
            req_d.word  = bus.word;
            req_d.comp  = bus.comp;
            req_d.write = bus.write;
            req_d.tag   = bus.tag_in;
            req_d.data  = bus.data_in;
            req_d.valid = bus.valid_in;
            state_d     = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        // Default result is the stored line contents before any write.
        hit_d   = hit_c;
        tag_d   = arr_rd_tag;
        data_d  = arr_rd_data;
        valid_d = arr_rd_valid;
        dirty_d = arr_rd_dirty;
        if (req_q.write) begin
          if (req_q.comp) begin
            if (hit_c) begin
              we_c         = 1'b1;
              arr_wr_tag   = arr_rd_tag;
              arr_wr_valid = 1'b1;
              arr_wr_dirty = 1'b1;
            end
          end else begin
            // Direct write reports the freshly written line.
            we_c    = 1'b1;
            tag_d   = req_q.tag;
            data_d  = req_q.data;
            valid_d = req_q.valid;
            dirty_d = 1'b0;
          end
        end
        state_d = ST_ACK;
      end

      ST_FLUSH: begin
        clr_c = 1'b1;
        if (cnt_q == idx_t'(LINES - 1)) begin
          if (from_rst_q) begin
            state_d = ST_IDLE;
          end else begin
            hit_d   = 1'b0;
            dirty_d = 1'b0;
            valid_d = 1'b0;
            tag_d   = '0;
            data_d  = '0;
            state_d = ST_ACK;
          end
        end else begin
          cnt_d = cnt_q + idx_t'(1);
        end
      end

      ST_ACK: begin
        if (!bus.en) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset drops into the flush walk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FLUSH;
      cnt_q      <= '0;
      from_rst_q <= 1'b1;
      req_q      <= '0;
      hit_q      <= 1'b0;
      dirty_q    <= 1'b0;
      valid_q    <= 1'b0;
      tag_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      from_rst_q <= from_rst_d;
      req_q      <= req_d;
      hit_q      <= hit_d;
      dirty_q    <= dirty_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
    end
  end

  assign bus.hit      = hit_q;
  assign bus.dirty    = dirty_q;
  assign bus.valid    = valid_q;
  assign bus.tag_out  = tag_q;
  assign bus.data_out = data_q;
  assign bus.ack      = (state_q == ST_ACK);
  assign bus.ready    = (state_q == ST_IDLE);

endmodule

// File: tb/tb_cache_bank.sv
// Directed bench for cache_bank: reset walk, compare/direct accesses, flush,
// early en drop and reset in the middle of an operation.
module tb_cache_bank;
  import cache_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  cache_bank_if bus ();

  cache_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic h, input logic d, input logic v,
                         input logic [4:0] t, input logic [15:0] dat);
    chk({nm, "_hit"},   32'(bus.hit),      32'(h));
    chk({nm, "_dirty"}, 32'(bus.dirty),    32'(d));
    chk({nm, "_valid"}, 32'(bus.valid),    32'(v));
    chk({nm, "_tag"},   32'(bus.tag_out),  32'(t));
    chk({nm, "_data"},  32'(bus.data_out), 32'(dat));
  endtask

  task automatic send(input logic c, input logic w, input logic [3:0] i, input logic [1:0] wd,
                      input logic [4:0] t, input logic [15:0] d, input logic v, input logic f);
    bus.comp     = c;
    bus.write    = w;
    bus.index    = i;
    bus.word     = wd;
    bus.tag_in   = t;
    bus.data_in  = d;
    bus.valid_in = v;
    bus.flush    = f;
    bus.en       = 1'b1;
  endtask

  task automatic wait_ack(input string nm, input int exp_lat);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.ack !== 1'b1 && n < 40);
    chk({nm, "_lat"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic release_req(input string nm);
    bus.en = 1'b0;
    tick();
    chk({nm, "_rdy"}, 32'(bus.ready), 32'd1);
    chk({nm, "_ack0"}, 32'(bus.ack), 32'd0);
  endtask

  task automatic reset_walk(input string nm);
    int n;
    logic ack_seen;
    n = 0;
    ack_seen = 1'b0;
    rst_n = 1'b1;
    while (bus.ready !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (bus.ack === 1'b1) ack_seen = 1'b1;
    end
    chk({nm, "_ready_lat"}, 32'(n), 32'd16);
    chk({nm, "_ack_seen"}, 32'(ack_seen), 32'd0);
  endtask

  initial begin
    bus.en = 1'b0; bus.comp = 1'b0; bus.write = 1'b0; bus.index = '0; bus.word = '0;
    bus.tag_in = '0; bus.data_in = '0; bus.valid_in = 1'b0; bus.flush = 1'b0;

    // reset state
    rst_n = 1'b0;
    tick(); tick(); tick();
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk_out("rst", 1'b0, 1'b0, 1'b0, 5'h00, 16'h0000);
    reset_walk("rst");

    // direct write line 3 word 2
    send(1'b0, 1'b1, 4'd3, 2'd2, 5'h0A, 16'hBEEF, 1'b1, 1'b0);
    wait_ack("dw3", 2);
    chk_out("dw3", 1'b0, 1'b0, 1'b1, 5'h0A, 16'hBEEF);
    release_req("dw3");

    // compare read hit
    send(1'b1, 1'b0, 4'd3, 2'd2, 5'h0A, 16'h0000, 1'b0, 1'b0);
    wait_ack("cr3", 2);
    chk_out("cr3", 1'b1, 1'b0, 1'b1, 5'h0A, 16'hBEEF);
    release_req("cr3");

    // compare write hit word 1; ack held while en stays high
    send(1'b1, 1'b1, 4'd3, 2'd1, 5'h0A, 16'h1234, 1'b0, 1'b0);
    wait_ack("cw3", 2);
    chk("cw3_hit", 32'(bus.hit), 32'd1);
    chk("cw3_dirty_pre", 32'(bus.dirty), 32'd0);
    chk("cw3_valid", 32'(bus.valid), 32'd1);
    tick(); tick();
    chk("cw3_hold_ack", 32'(bus.ack), 32'd1);
    chk("cw3_hold_hit", 32'(bus.hit), 32'd1);
    chk("cw3_hold_dirty", 32'(bus.dirty), 32'd0);
    release_req("cw3");

    // compare read word 1 sees the written word and dirty line
    send(1'b1, 1'b0, 4'd3, 2'd1, 5'h0A, 16'h0000, 1'b0, 1'b0);
    wait_ack("cr3w1", 2);
    chk_out("cr3w1", 1'b1, 1'b1, 1'b1, 5'h0A, 16'h1234);
    release_req("cr3w1");

    // compare read with wrong tag
    send(1'b1, 1'b0, 4'd3, 2'd2, 5'h0B, 16'h0000, 1'b0, 1'b0);
    wait_ack("crmiss", 2);
    chk_out("crmiss", 1'b0, 1'b1, 1'b1, 5'h0A, 16'hBEEF);
    release_req("crmiss");

    // compare write miss leaves the array untouched
    send(1'b1, 1'b1, 4'd3, 2'd2, 5'h0B, 16'hDEAD, 1'b0, 1'b0);
    wait_ack("cwmiss", 2);
    chk_out("cwmiss", 1'b0, 1'b1, 1'b1, 5'h0A, 16'hBEEF);
    release_req("cwmiss");
    send(1'b1, 1'b0, 4'd3, 2'd2, 5'h0A, 16'h0000, 1'b0, 1'b0);
    wait_ack("cwmiss_rd", 2);
    chk_out("cwmiss_rd", 1'b1, 1'b1, 1'b1, 5'h0A, 16'hBEEF);
    release_req("cwmiss_rd");

    // direct write with valid_in=0, then compare read must miss
    send(1'b0, 1'b1, 4'd5, 2'd0, 5'h1F, 16'h5555, 1'b0, 1'b0);
    wait_ack("dw5", 2);
    chk_out("dw5", 1'b0, 1'b0, 1'b0, 5'h1F, 16'h5555);
    release_req("dw5");
    send(1'b1, 1'b0, 4'd5, 2'd0, 5'h1F, 16'h0000, 1'b0, 1'b0);
    wait_ack("cr5", 2);
    chk_out("cr5", 1'b0, 1'b0, 1'b0, 5'h1F, 16'h5555);
    release_req("cr5");

    // flush
    send(1'b1, 1'b0, 4'd3, 2'd2, 5'h0A, 16'h0000, 1'b0, 1'b1);
    wait_ack("flush", 17);
    chk_out("flush", 1'b0, 1'b0, 1'b0, 5'h00, 16'h0000);
    release_req("flush");
    send(1'b1, 1'b0, 4'd3, 2'd2, 5'h0A, 16'h0000, 1'b0, 1'b0);
    wait_ack("postflush", 2);
    chk_out("postflush", 1'b0, 1'b0, 1'b0, 5'h0A, 16'hBEEF);
    release_req("postflush");

    // en dropped one cycle after capture, inputs scrambled in flight
    send(1'b0, 1'b0, 4'd3, 2'd1, 5'h00, 16'h0000, 1'b0, 1'b0);
    tick();
    bus.en = 1'b0; bus.comp = 1'b1; bus.write = 1'b1; bus.index = 4'd5; bus.word = 2'd0;
    bus.tag_in = 5'h1F; bus.data_in = 16'hFFFF; bus.valid_in = 1'b1; bus.flush = 1'b1;
    tick();
    chk("drop_ack1", 32'(bus.ack), 32'd1);
    chk_out("drop", 1'b0, 1'b0, 1'b0, 5'h0A, 16'h1234);
    tick();
    chk("drop_ack0", 32'(bus.ack), 32'd0);
    chk("drop_ready", 32'(bus.ready), 32'd1);
    send(1'b0, 1'b0, 4'd5, 2'd0, 5'h00, 16'h0000, 1'b0, 1'b0);
    wait_ack("drop_rd5", 2);
    chk_out("drop_rd5", 1'b0, 1'b0, 1'b0, 5'h1F, 16'h5555);
    release_req("drop_rd5");

    // reset in the middle of a direct write aborts it
    send(1'b0, 1'b1, 4'd7, 2'd3, 5'h01, 16'h1111, 1'b1, 1'b0);
    wait_ack("dw7", 2);
    release_req("dw7");
    send(1'b0, 1'b1, 4'd7, 2'd3, 5'h03, 16'hA5A5, 1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    bus.en = 1'b0;
    chk("abort_ack", 32'(bus.ack), 32'd0);
    chk("abort_ready", 32'(bus.ready), 32'd0);
    chk_out("abort", 1'b0, 1'b0, 1'b0, 5'h00, 16'h0000);
    reset_walk("abort");
    send(1'b0, 1'b0, 4'd7, 2'd3, 5'h00, 16'h0000, 1'b0, 1'b0);
    wait_ack("abort_rd", 2);
    chk_out("abort_rd", 1'b0, 1'b0, 1'b0, 5'h01, 16'h1111);
    release_req("abort_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
